// File: rtl/mod47_exp_fsm.sv
// rtl/mod47_exp_fsm.sv - constant-time right-to-left square-and-multiply base^exp mod 47
// One shared combinational mod-47 multiplier is time-multiplexed between the multiply and square steps.

module mul6ABmod47 (
  input  logic [5:0] i_a,
  input  logic [5:0] i_b,
  output logic [5:0] o_r
);
  logic [11:0] w_prod;

  assign w_prod = {6'd0, i_a} * {6'd0, i_b};
  assign o_r    = 6'(w_prod % 12'd47);
endmodule

module mod47_exp_fsm #(
  parameter int EXP_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [5:0]       i_base,
  input  logic [EXP_W-1:0] i_exp,
  output logic             o_busy,
  output logic             o_done,
  output logic [5:0]       o_result
);
  localparam int CNT_W = $clog2(EXP_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SQR, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_acc;
  logic [5:0]         r_sq;
  logic [EXP_W-1:0]   r_e;
  logic [CNT_W-1:0]   r_cnt;
  logic [5:0]         r_result;
  logic [5:0]         w_mul_a;
  logic [5:0]         w_mul_b;
  logic [5:0]         w_mul_r;
  logic [5:0]         w_base_red;
  logic               w_last;

  mul6ABmod47 u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_r (w_mul_r)
  );

  // 6-bit base never exceeds 63, so one conditional subtract fully reduces it.
  assign w_base_red = (i_base >= 6'd47) ? (i_base - 6'd47) : i_base;
  assign w_last     = (r_cnt == CNT_W'(EXP_W - 1));

  always_comb begin
    w_next  = r_state;
    w_mul_a = r_sq;
    w_mul_b = r_sq;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_MUL;
      S_MUL: begin
        w_mul_a = r_acc;
        w_next  = S_SQR;
      end
      S_SQR:  w_next = w_last ? S_DONE : S_MUL;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_acc    <= 6'd0;
      r_sq     <= 6'd0;
      r_e      <= '0;
      r_cnt    <= '0;
      r_result <= 6'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc <= 6'd1;
            r_sq  <= w_base_red;
            r_e   <= i_exp;
            r_cnt <= '0;
          end
        end
        // Product is always formed; the exponent bit only picks whether to keep it.
        S_MUL: begin
          if (r_e[0]) r_acc <= w_mul_r;
        end
        S_SQR: begin
          r_sq  <= w_mul_r;
          r_e   <= r_e >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_result <= r_acc;
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_result = r_result;
endmodule
